// File: rtl/dmem_pkg.sv
// Shared constants, op codes and FSM states for the block mover.
package dmem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 9;

  typedef enum logic [1:0] {
    OP_COPY  = 2'b00,
    OP_FILL  = 2'b01,
    OP_CHECK = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, COPY_RD, COPY_WR, FILL_WR, CHK_RD, CHK_DRAIN, DONE
  } state_e;
endpackage

// File: rtl/dmem_block_mover_if.sv
// Command, memory-port and status bundle between the engine and its surroundings.
interface dmem_block_mover_if;
  import dmem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_fill;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write_en;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, mem_rdata,
    output cmd_ready, mem_address, mem_wdata, mem_write_en, mem_read_en,
           busy, done, result
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_fill, mem_rdata,
    input  cmd_ready, mem_address, mem_wdata, mem_write_en, mem_read_en,
           busy, done, result
  );
endinterface

// File: rtl/dmem_xfer_counter.sv
// Word index with last-word detect and wrapped base+index address.
module dmem_xfer_counter #(
  parameter int LEN_W  = 9,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  logic [LEN_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst)      idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + LEN_W'(1);
  end

  // full-width compare so len=256 runs all 256 words
  assign last = (idx == len - LEN_W'(1));
  assign addr = base + idx[ADDR_W-1:0];
endmodule

// File: rtl/dmem_block_mover.sv
// Block COPY/FILL/CHECK engine owning the single-port data memory while busy.
module dmem_block_mover
  import dmem_pkg::*;
(
  input logic clk,
  input logic rst,
  dmem_block_mover_if.master bus
);
  state_e            state;
  logic [ADDR_W-1:0] src_q, dst_q, base, addr;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fill_q, acc, acc_nxt, result_q;
  logic              ready_q, busy_q, done_q, rd_en, wr_en, rd_vld;
  logic              last, accept, inc;

  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign inc     = (state == COPY_WR) || (state == FILL_WR) || (state == CHK_RD);
  assign base    = (state == COPY_WR || state == FILL_WR) ? dst_q : src_q;
  assign acc_nxt = acc ^ (rd_vld ? bus.mem_rdata : '0);

  dmem_xfer_counter #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (inc),
    .len  (len_q),
    .base (base),
    .last (last),
    .addr (addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      rd_vld   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      rd_en  <= 1'b0;
      wr_en  <= 1'b0;
      // read data lands one cycle after the CHK_RD strobe
      rd_vld <= (state == CHK_RD);
      acc    <= acc_nxt;
      unique case (state)
        IDLE: if (accept) begin
          src_q   <= bus.cmd_src;
          dst_q   <= bus.cmd_dst;
          len_q   <= bus.cmd_len;
          fill_q  <= bus.cmd_fill;
          acc     <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          if (bus.cmd_len == '0 || bus.cmd_op == OP_RSVD) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            unique case (bus.cmd_op)
              OP_COPY: begin state <= COPY_RD; rd_en <= 1'b1; end
              OP_FILL: begin state <= FILL_WR; wr_en <= 1'b1; end
              default: begin state <= CHK_RD;  rd_en <= 1'b1; end
            endcase
          end
        end
        COPY_RD: begin state <= COPY_WR; wr_en <= 1'b1; end
        COPY_WR:
          if (last) begin state <= DONE;    done_q <= 1'b1; end
          else      begin state <= COPY_RD; rd_en  <= 1'b1; end
        FILL_WR:
          if (last) begin state <= DONE; done_q <= 1'b1; end
          else      wr_en <= 1'b1;
        CHK_RD:
          if (last) state <= CHK_DRAIN;
          else      rd_en <= 1'b1;
        CHK_DRAIN: begin
          result_q <= acc_nxt;
          state    <= DONE;
          done_q   <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.mem_read_en  = rd_en;
  assign bus.mem_write_en = wr_en;
  assign bus.mem_address  = addr;
  // copy data goes straight from the read port to the write port
  assign bus.mem_wdata    = (state == COPY_WR) ? bus.mem_rdata :
                            (state == FILL_WR) ? fill_q : '0;
endmodule

// File: tb/tb_dmem_block_mover.sv
// Randomised bench for dmem_block_mover against a word-level memory model.
module tb_dmem_block_mover;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_block_mover_if bus ();
  dmem_block_mover dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] ram [256];
  logic [63:0] mdl [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [63:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.mem_write_en) ram[bus.mem_address] <= bus.mem_wdata;
    if (bus.mem_read_en) bus.mem_rdata <= ram[bus.mem_address];
  end

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [63:0] data;
  } strobe_t;

  strobe_t     obs[$];
  strobe_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] exp_result = '0;

  always @(negedge clk) begin
    if (bus.mem_read_en || bus.mem_write_en)
      obs.push_back('{bus.mem_write_en, bus.mem_address,
                      bus.mem_write_en ? bus.mem_wdata : 64'h0});
    if (bus.done) done_cnt++;
    checks++;
    if (bus.mem_read_en && bus.mem_write_en) begin
      errors++;
      $display("FAIL strobe_excl: read_en=1 write_en=1, required not both");
    end
  end

  task automatic model(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                       input logic [8:0] len, input logic [63:0] fill, output int lat);
    logic [7:0]  s, d;
    logic [63:0] x;
    x = '0;
    exp_q.delete();
    if (len == 0 || op == 2'b11) lat = 1;
    else if (op == 2'b00) lat = 2 * int'(len) + 1;
    else if (op == 2'b01) lat = int'(len) + 1;
    else lat = int'(len) + 2;
    if (op != 2'b11) begin
      for (int i = 0; i < int'(len); i++) begin
        s = src + 8'(i);
        d = dst + 8'(i);
        case (op)
          2'b00: begin
            exp_q.push_back('{1'b0, s, 64'h0});
            exp_q.push_back('{1'b1, d, mdl[s]});
            mdl[d] = mdl[s];
          end
          2'b01: begin
            exp_q.push_back('{1'b1, d, fill});
            mdl[d] = fill;
          end
          default: begin
            exp_q.push_back('{1'b0, s, 64'h0});
            x = x ^ mdl[s];
          end
        endcase
      end
      if (op == 2'b10 && len != 0) exp_result = x;
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                           input logic [8:0] len, input logic [63:0] fill);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = len;
    bus.cmd_fill  = fill;
  endtask

  task automatic scramble_fields();
    bus.cmd_op   = 2'($urandom);
    bus.cmd_src  = 8'($urandom);
    bus.cmd_dst  = 8'($urandom);
    bus.cmd_len  = 9'($urandom);
    bus.cmd_fill = {$urandom, $urandom};
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                         input logic [8:0] len, input logic [63:0] fill, input string nm);
    int lat, k, bad;
    bit got;
    model(op, src, dst, len, fill, lat);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", nm, bus.cmd_ready);
    end
    drive_cmd(op, src, dst, len, fill);
    obs.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    scramble_fields();
    k = 0; got = 0;
    while (!got && k < 2 * int'(len) + 10) begin
      @(negedge clk); k++;
      if (k == 1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL %s busy_T1: busy=%b ready=%b want 1/0", nm, bus.busy, bus.cmd_ready);
        end
      end
      if (bus.done === 1'b1) got = 1;
    end
    checks++;
    if (!got || k != lat) begin
      errors++; $display("FAIL %s done_latency: got %0d (seen=%0d) want %0d", nm, k, got, lat);
    end
    checks++;
    if (bus.result !== exp_result) begin
      errors++; $display("FAIL %s result: got %h want %h", nm, bus.result, exp_result);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: ready=%b busy=%b done=%b want 1/0/0",
                         nm, bus.cmd_ready, bus.busy, bus.done);
    end
    checks++;
    bad = 0;
    if (obs.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (obs[i] !== exp_q[i]) bad++;
    if (bad != 0) begin
      errors++; $display("FAIL %s strobe_trace: got %0d strobes (%0d bad) want %0d",
                         nm, obs.size(), bad, exp_q.size());
    end
    checks++;
    bad = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== mdl[a]) bad++;
    if (bad != 0) begin
      errors++; $display("FAIL %s memory: %0d words differ, want 0", nm, bad);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 64'h0 || bus.mem_read_en !== 1'b0 || bus.mem_write_en !== 1'b0 ||
        bus.mem_address !== 8'h0 || bus.mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b done=%b result=%h rd=%b wr=%b addr=%h wdata=%h want 1/0/0/0/0/0/0/0",
               nm, bus.cmd_ready, bus.busy, bus.done, bus.result, bus.mem_read_en,
               bus.mem_write_en, bus.mem_address, bus.mem_wdata);
    end
  endtask

  task automatic test_reset();
    logic [63:0] v;
    bus.cmd_valid = 1'b0;
    scramble_fields();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = (i <= 16) ? 64'(i + 1) : {$urandom, $urandom};
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = v; mdl[i] = v;
    end
    @(negedge clk);
    ld_en = 1'b0;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_check();
    run_cmd(2'b10, 8'h00, 8'h00, 9'd4, 64'h0, "check_len4");
    checks++;
    if (bus.result !== 64'h4) begin
      errors++; $display("FAIL check_const: got %h want 4", bus.result);
    end
  endtask

  task automatic test_fill();
    run_cmd(2'b01, 8'h00, 8'hFE, 9'd3, 64'hA5A5, "fill_wrap");
    checks++;
    if (ram[8'hFE] !== 64'hA5A5 || ram[8'hFF] !== 64'hA5A5 || ram[8'h00] !== 64'hA5A5) begin
      errors++; $display("FAIL fill_readback: got %h %h %h want a5a5", ram[8'hFE], ram[8'hFF], ram[8'h00]);
    end
  endtask

  task automatic test_copy();
    run_cmd(2'b00, 8'h01, 8'h40, 9'd2, 64'h0, "copy_len2");
    checks++;
    if (ram[8'h40] !== 64'h2 || ram[8'h41] !== 64'h3) begin
      errors++; $display("FAIL copy_readback: got %h %h want 2 3", ram[8'h40], ram[8'h41]);
    end
  endtask

  task automatic test_len_zero();
    run_cmd(2'b00, 8'h10, 8'h20, 9'd0, 64'h0, "copy_len0");
    run_cmd(2'b01, 8'h10, 8'h20, 9'd0, 64'h1234, "fill_len0");
    run_cmd(2'b10, 8'h10, 8'h20, 9'd0, 64'h0, "check_len0");
    run_cmd(2'b11, 8'h10, 8'h20, 9'd5, 64'h77, "reserved_op");
  endtask

  task automatic test_reset_mid();
    int lat, bad;
    logic [63:0] saved [256];
    saved = mdl;
    model(2'b00, 8'h00, 8'h60, 9'd3, 64'h0, lat);
    // only the first three words land before the abort
    for (int i = 3; i < 8; i++) mdl[8'h60 + i] = saved[8'h60 + i];
    exp_result = '0;
    @(negedge clk);
    drive_cmd(2'b00, 8'h00, 8'h60, 9'd8, 64'h0);
    obs.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_cmd");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_mid_hold");
    rst = 1'b0;
    checks++;
    bad = 0;
    if (obs.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (obs[i] !== exp_q[i]) bad++;
    if (bad != 0 || done_cnt != 0) begin
      errors++; $display("FAIL reset_mid_strobes: got %0d strobes (%0d bad) done=%0d want %0d strobes done=0",
                         obs.size(), bad, done_cnt, exp_q.size());
    end
    run_cmd(2'b10, 8'h60, 8'h00, 9'd3, 64'h0, "after_reset_check");
  endtask

  task automatic test_back_to_back();
    logic [8:0]  done_seen, ready_seen;
    logic [63:0] fa, fb;
    int bad;
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    done_seen = '0; ready_seen = '0;
    @(negedge clk);
    drive_cmd(2'b01, 8'h00, 8'h80, 9'd2, fa);
    @(posedge clk); #1;
    drive_cmd(2'b01, 8'h00, 8'h90, 9'd3, fb);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      done_seen[k-1]  = bus.done;
      ready_seen[k-1] = bus.cmd_ready;
      if (k == 8) bus.cmd_valid = 1'b0;
    end
    checks++;
    if (done_seen !== 9'b0_1000_0100) begin
      errors++; $display("FAIL b2b_done_pattern: got %b want 010000100", done_seen);
    end
    checks++;
    if (ready_seen !== 9'b1_0000_1000) begin
      errors++; $display("FAIL b2b_ready_pattern: got %b want 100001000", ready_seen);
    end
    for (int i = 0; i < 2; i++) mdl[8'h80 + i] = fa;
    for (int i = 0; i < 3; i++) mdl[8'h90 + i] = fb;
    checks++;
    bad = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== mdl[a]) bad++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_memory: %0d words differ, want 0", bad);
    end
  endtask

  task automatic test_boundary();
    run_cmd(2'b10, 8'h10, 8'h00, 9'd256, 64'h0, "check_len256");
    run_cmd(2'b00, 8'h20, 8'h22, 9'd6, 64'h0, "copy_overlap_up");
    run_cmd(2'b00, 8'hFC, 8'h00, 9'd256, 64'h0, "copy_len256_wrap");
    run_cmd(2'b10, 8'h00, 8'h00, 9'd256, 64'h0, "check_after_copy256");
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [8:0] len;
    for (int n = 0; n < 16; n++) begin
      op  = 2'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 24));
      run_cmd(op, 8'($urandom), 8'($urandom), len, {$urandom, $urandom}, "random");
    end
  endtask

  initial begin
    test_reset();
    test_check();
    test_fill();
    test_copy();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
- Initiator-side engine that drives the single-port 64-bit data memory (8-bit address, write_en/read_en, one-cycle registered read).
- Executes block commands against it: COPY (src range to dst range), FILL (constant into dst range) and CHECK (XOR-checksum of src range).
- Sits between the control path and data memory; it owns the memory port while busy.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap mod 2^ADDR_W.
- DATA_W, 64, memory word width.
- LEN_W, 9, command length width; lengths 0..256 are legal.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept; high only in IDLE.
- cmd_op  in  2  00 COPY, 01 FILL, 10 CHECK, 11 reserved.
- cmd_src  in  ADDR_W  source base address.
- cmd_dst  in  ADDR_W  destination base address.
- cmd_len  in  LEN_W  word count.
- cmd_fill  in  DATA_W  FILL pattern.
- mem_address  out  ADDR_W  to memory mem_address.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_write_en  out  1  to memory write_en.
- mem_read_en  out  1  to memory read_en.
- mem_rdata  in  DATA_W  from memory data_out; valid the cycle after mem_read_en.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- result  out  DATA_W  CHECK checksum; holds its value until the next CHECK completes.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; busy=0; done=0; result=0; mem_write_en=0; mem_read_en=0; mem_address=0; mem_wdata=0; internal index, base and length registers 0.
- Reset mid-command: abort in the same edge. No further memory strobes, no done pulse, result unchanged from 0.
- Acceptance: cmd_valid && cmd_ready at edge T latches op, src, dst, len and fill. cmd_ready and busy drop from T+1.
- Index: i counts 0..len-1. Addresses are (base+i) mod 256, so 255 wraps to 0.
- Strobe exclusivity: mem_write_en and mem_read_en are never high in the same cycle. Both are low in IDLE and DONE.
- States and transitions:
  - IDLE -> COPY_RD, FILL_WR or CHK_RD per op.
  - IDLE -> DONE directly when len==0 or op==11; no memory access occurs.
  - COPY_RD: read_en=1, address=src+i. Next state COPY_WR.
  - COPY_WR: write_en=1, address=dst+i, wdata=mem_rdata (combinational pass-through), i++. Next state is COPY_RD, or DONE when i==len-1.
  - COPY cost: 2 cycles per word. done is high in cycle T+2·len+1.
  - COPY runs in ascending order. Overlap with dst>src propagates already-copied words; this is defined behaviour, not an error.
  - FILL_WR: write_en=1, address=dst+i, wdata=fill, one word per cycle. DONE after i==len-1; done at T+len+1.
  - CHK_RD: read_en=1, address=src+i, one per cycle for len cycles (pipelined). A one-cycle-delayed valid flag XORs mem_rdata into the accumulator.
  - CHK_DRAIN: one cycle, absorbs the last read.
  - CHECK completion: DONE at T+len+2, with result=accumulator visible in the same cycle as done. The accumulator clears on acceptance.
  - DONE: done=1 for one cycle, then IDLE. cmd_ready stays low during DONE.
- Width rules:
  - The length comparison uses the full LEN_W bits. len=256 covers every address exactly once.
  - The index register is LEN_W wide; addresses use its low ADDR_W bits.

Decomposition:
- Shared package dmem_pkg holds:
  - ADDR_W and DATA_W constants;
  - op codes OP_COPY, OP_FILL, OP_CHECK, OP_RSVD;
  - the state enum (IDLE, COPY_RD, COPY_WR, FILL_WR, CHK_RD, CHK_DRAIN, DONE).
- One sub-module is natural: dmem_xfer_counter. It holds the index register, the last-word flag and the wrapped address add, parameterised by LEN_W and ADDR_W.

Test Plan:
- Memory preloaded with ram[i]=i+1 for i=0..16. CHECK src=0 len=4 -> four consecutive read_en cycles at addresses 0..3; done at T+6; result=0x4 (1^2^3^4).
- FILL dst=0xFE len=3 fill=0xA5A5 -> writes at 0xFE, 0xFF, 0x00 on consecutive cycles; a readback of those addresses gives 0xA5A5; done at T+4.
- COPY src=0 dst=0x40 len=2 -> strobe order RD0, WR40 (data 1), RD1, WR41 (data 2); done at T+5; read_en and write_en are never coincident.
- len=0 for any op, and op=11 -> no strobes; done at T+1; cmd_ready back high at T+2.
- Reset asserted during COPY len=8 after 3 words -> strobes stop at the reset edge; no done; every output reads its reset value; a new command is accepted immediately after rst deasserts.
- cmd_valid held high across back-to-back commands -> the second command is accepted only in the IDLE cycle after done; command fields sampled at acceptance are unaffected by later input changes.
